// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC generation feeding a fetch queue toward decode.
// Optional macro FETCH_QUEUE_BPRED_EN enables use of the branch prediction inputs.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC   = 32'h1000,
  parameter logic [31:0] EXC_VECTOR = 32'h2000,
  parameter int          DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  input  logic                       exc_i,
  input  logic                       iret_i,
  input  logic [31:0]                exc_return_pc_i,
  input  logic                       stall_i,
  output logic [31:0]                bp_pc_o,
  input  logic                       bp_taken_i,
  input  logic [31:0]                bp_target_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_pc_o,
  output logic                       out_taken_o,
  output logic [31:0]                out_target_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_q_pc [DEPTH];

  logic          w_flush;
  logic          w_pop;
  logic          w_push;
  logic          w_pred_taken;
  logic [31:0]   w_pred_target;
  logic [31:0]   w_pc_seq;
  logic [31:0]   w_pc_next;

`ifdef FETCH_QUEUE_BPRED_EN
  logic          r_q_taken  [DEPTH];
  logic [31:0]   r_q_target [DEPTH];

  assign w_pred_taken  = bp_taken_i;
  assign w_pred_target = bp_target_i;
  assign out_taken_o   = r_q_taken[r_rptr];
  assign out_target_o  = r_q_target[r_rptr];
`else
  logic          w_unused_bp;

  assign w_unused_bp   = bp_taken_i ^ (^bp_target_i);
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = 32'h0;
  assign out_taken_o   = 1'b0;
  assign out_target_o  = 32'h0;
`endif

  assign bp_pc_o     = r_pc;
  assign count_o     = r_count;
  assign out_valid_o = (r_count != '0);
  assign out_pc_o    = r_q_pc[r_rptr];

  // Any flush source kills both queue ports for the cycle.
  assign w_flush  = iret_i | exc_i | redirect_i;
  assign w_pop    = out_valid_o & out_ready_i & ~w_flush;
  assign w_push   = ~w_flush & ~stall_i & ((r_count < CW'(DEPTH)) | w_pop);
  assign w_pc_seq = r_pc + 32'd4;

  always_comb begin
    w_pc_next = r_pc;
    if (iret_i)
      w_pc_next = exc_return_pc_i + 32'd4;
    else if (exc_i)
      w_pc_next = EXC_VECTOR;
    else if (redirect_i)
      w_pc_next = redirect_pc_i;
    else if (w_push)
      w_pc_next = w_pred_taken ? w_pred_target : w_pc_seq;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i] <= 32'h0;
`ifdef FETCH_QUEUE_BPRED_EN
        r_q_taken[i]  <= 1'b0;
        r_q_target[i] <= 32'h0;
`endif
      end
    end else begin
      r_pc <= w_pc_next;
      if (w_flush) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) begin
          r_q_pc[r_wptr] <= r_pc;
`ifdef FETCH_QUEUE_BPRED_EN
          r_q_taken[r_wptr]  <= w_pred_taken;
          r_q_target[r_wptr] <= w_pred_target;
`endif
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop)
          r_rptr <= r_rptr + 1'b1;
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1000: PC loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h2000: PC loaded on exception.
REQ-003 SHALL have parameter DEPTH, default 4 (power of two, 2..16): fetch-queue entries.
REQ-004 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port redirect_i, input, 1: mispredict redirect from ALU.
REQ-007 SHALL have port redirect_pc_i, input, 32: mispredict target.
REQ-008 SHALL have port exc_i, input, 1: exception occurred.
REQ-009 SHALL have port iret_i, input, 1: return from exception.
REQ-010 SHALL have port exc_return_pc_i, input, 32: PC of trapping instruction.
REQ-011 SHALL have port stall_i, input, 1: freeze PC generation.
REQ-012 SHALL have port bp_pc_o, output, 32: current PC to predictor.
REQ-013 SHALL have port bp_taken_i, input, 1, and bp_target_i, input, 32: combinational prediction for bp_pc_o.
REQ-014 SHALL have ports out_valid_o (1), out_ready_i (1), out_pc_o (32), out_taken_o (1), out_target_o (32): queue head to decode.
REQ-015 SHALL have port count_o, output, clog2(DEPTH)+1: occupied entries.

Function
REQ-016 SHALL hold PC register pc; bp_pc_o = pc combinationally.
REQ-017 SHALL compute next sequential PC as pc+4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-018 SHALL select next pc by priority: rst_i > iret_i > exc_i > redirect_i > push > hold.
REQ-019 iret_i SHALL load pc <= exc_return_pc_i+4, flush queue.
REQ-020 exc_i SHALL load pc <= EXC_VECTOR, flush queue.
REQ-021 redirect_i SHALL load pc <= redirect_pc_i, flush queue.
REQ-022 Flush SHALL set count to 0 and suppress both push and pop in that cycle; out_valid_o low next cycle.
REQ-023 Push SHALL occur when no flush, stall_i low, and (count<DEPTH or pop this cycle); entry = {pc, taken, target}.
REQ-024 On push, pc SHALL advance to bp_target_i if predicted taken, else pc+4.
REQ-025 Pop SHALL occur when out_valid_o and out_ready_i and no flush.
REQ-026 Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-027 out_valid_o SHALL equal (count!=0); head fields SHALL be registered queue contents, stable while valid and not popped.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-029 Fetch latency SHALL be one cycle: PC pushed at edge N is visible at head at N+1 if queue was empty.
REQ-030 stall_i SHALL freeze pc and pushes only; pops continue.

Reset
REQ-031 On rst_i high at a clock edge: pc <= RESET_PC, count <= 0, pointers <= 0, regardless of other inputs.
REQ-032 After reset: out_valid_o=0, count_o=0, bp_pc_o=RESET_PC, out_pc_o/out_taken_o/out_target_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries in that cycle.

Configuration
REQ-034 Macro FETCH_QUEUE_BPRED_EN defined: prediction used per REQ-024, out_taken_o/out_target_o carry queued values.
REQ-035 Macro FETCH_QUEUE_BPRED_EN undefined: bp_taken_i/bp_target_i ignored, pc always advances pc+4, out_taken_o=0, out_target_o=0.

Verification
REQ-036 Reset, out_ready_i=1, no events -> out_pc_o sequence 0x1000,0x1004,0x1008 from cycle 1 after reset, count_o<=1.
REQ-037 out_ready_i=0 for 6 cycles -> count_o 1,2,3,4,4,4; pc held at 0x1010; release -> pops 0x1000.. in order, no loss/duplicate.
REQ-038 Queue holds 3 entries, redirect_i=1 redirect_pc_i=0x2400 -> next cycle count_o=0, out_valid_o=0; following cycle out_pc_o=0x2400.
REQ-039 exc_i and redirect_i same cycle -> pc=0x2000; then iret_i with exc_return_pc_i=0x1234 -> pc=0x1238, queue flushed.
REQ-040 BPRED_EN, bp_taken_i=1 bp_target_i=0x1800 at pc 0x1004 -> entry {0x1004,1,0x1800}, next entry pc 0x1800; without macro next is 0x1008, taken=0.
REQ-041 rst_i asserted with full queue and stall_i=1 -> next cycle count_o=0, bp_pc_o=0x1000.
